cgb_palette_unit: RTL and testbench

Parametrised CGB colour-palette subsystem for the PPU. It generalises the fixed BG/OBJ palette RAM pair to N palette tables, each with a CPU-visible index register (auto-increment) and data register. It enforces CPU access lockout while the PPU is in mode 3 and provides a registered 1-cycle colour lookup port to the pixel pipeline.

---
 rtl/ppu_pkg.sv | 9 +
 rtl/palette_table.sv | 57 +++++
 rtl/cgb_palette_unit.sv | 112 +++++++++++
 tb/tb_cgb_palette_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU types and constants for the CGB palette subsystem.
package ppu_pkg;

   typedef logic [14:0] bgr555_t;

   localparam int unsigned SPEC_AINC_BIT = 7;
   localparam logic [7:0]  LOCKED_RDATA  = 8'hFF;

endpackage

// File: rtl/palette_table.sv
// One palette RAM with its spec (index) register, CPU port and a 2-byte lookup read port.
module palette_table
   import ppu_pkg::*;
#(
   parameter int unsigned IDX_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             spec_wr,
   input  logic             data_wr,
   input  logic             locked,
   input  logic [7:0]       wdata,
   output logic [7:0]       spec_rdata,
   output logic [7:0]       data_rdata,
   input  logic [IDX_W-2:0] lk_entry,
   output logic [7:0]       lk_lo,
   output logic [6:0]       lk_hi
);

   localparam int unsigned DEPTH = 2 ** IDX_W;

   logic [7:0]       mem_q [DEPTH];
   logic             ainc_q;
   logic [IDX_W-1:0] index_q;

   // A locked data write still advances the index so CPU bursts stay aligned.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         ainc_q  <= 1'b0;
         index_q <= '0;
      end else if (spec_wr) begin
         ainc_q  <= wdata[SPEC_AINC_BIT];
         index_q <= wdata[IDX_W-1:0];
      end else if (data_wr) begin
         if (!locked) begin
            mem_q[index_q] <= wdata;
         end
         if (ainc_q) begin
            index_q <= index_q + 1'b1;
         end
      end
   end

   always_comb begin
      spec_rdata                = '1;
      spec_rdata[SPEC_AINC_BIT] = ainc_q;
      spec_rdata[IDX_W-1:0]     = index_q;
   end

   assign data_rdata = mem_q[index_q];
   assign lk_lo      = mem_q[{lk_entry, 1'b0}];
   assign lk_hi      = mem_q[{lk_entry, 1'b1}][6:0];

endmodule

// File: rtl/cgb_palette_unit.sv
// CGB palette subsystem: N palette tables behind CPU spec/data registers, plus a
// registered one-cycle colour lookup port for the pixel pipeline.
module cgb_palette_unit
   import ppu_pkg::*;
#(
   parameter int unsigned NUM_TABLES = 2,
   parameter int unsigned PALETTES   = 8,
   parameter int unsigned COLORS     = 4,
   localparam int unsigned IDX_W     = $clog2(PALETTES * COLORS * 2),
   localparam int unsigned TBL_W     = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1,
   localparam int unsigned PAL_W     = $clog2(PALETTES),
   localparam int unsigned COL_W     = $clog2(COLORS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_en,
   input  logic [TBL_W:0]   reg_addr,
   input  logic             reg_wr,
   input  logic             reg_rd,
   input  logic [7:0]       reg_wdata,
   output logic [7:0]       reg_rdata,
   input  logic             ppu_mode3,
   input  logic             lk_valid,
   input  logic [TBL_W-1:0] lk_table,
   input  logic [PAL_W-1:0] lk_palette,
   input  logic [COL_W-1:0] lk_color,
   output logic             color_valid,
   output logic [14:0]      color
);

   logic [TBL_W-1:0] reg_tbl;
   logic             reg_sel;
   logic             reg_tbl_ok;
   logic             lk_tbl_ok;
   logic             wr_go;
   logic [IDX_W-2:0] lk_entry;

   logic [7:0] spec_rd [NUM_TABLES];
   logic [7:0] data_rd [NUM_TABLES];
   logic [7:0] lk_lo   [NUM_TABLES];
   logic [6:0] lk_hi   [NUM_TABLES];

   bgr555_t lk_result;
   bgr555_t color_q;
   logic    color_valid_q;

   // Read strobe carries no side effect in this design.
   logic unused_rd;
   assign unused_rd = reg_rd;

   assign reg_tbl    = reg_addr[TBL_W:1];
   assign reg_sel    = reg_addr[0];
   assign reg_tbl_ok = 32'(reg_tbl) < NUM_TABLES;
   assign lk_tbl_ok  = 32'(lk_table) < NUM_TABLES;
   assign wr_go      = cpu_en & reg_wr & reg_tbl_ok;
   assign lk_entry   = {lk_palette, lk_color};

   for (genvar t = 0; t < NUM_TABLES; t++) begin : g_table
      localparam logic [TBL_W-1:0] TBL_ID = TBL_W'(t);

      palette_table #(
         .IDX_W (IDX_W)
      ) u_table (
         .clk        (clk),
         .reset      (reset),
         .spec_wr    (wr_go & ~reg_sel & (reg_tbl == TBL_ID)),
         .data_wr    (wr_go & reg_sel & (reg_tbl == TBL_ID)),
         .locked     (ppu_mode3),
         .wdata      (reg_wdata),
         .spec_rdata (spec_rd[t]),
         .data_rdata (data_rd[t]),
         .lk_entry   (lk_entry),
         .lk_lo      (lk_lo[t]),
         .lk_hi      (lk_hi[t])
      );
   end

   always_comb begin
      reg_rdata = '0;
      if (reg_tbl_ok) begin
         if (!reg_sel) begin
            reg_rdata = spec_rd[reg_tbl];
         end else if (ppu_mode3) begin
            reg_rdata = LOCKED_RDATA;
         end else begin
            reg_rdata = data_rd[reg_tbl];
         end
      end
   end

   always_comb begin
      lk_result = '0;
      if (lk_tbl_ok) begin
         lk_result = {lk_hi[lk_table], lk_lo[lk_table]};
      end
   end

   // RAM is read combinationally here, so a same-cycle CPU write lands after the sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         color_q       <= '0;
         color_valid_q <= 1'b0;
      end else if (cpu_en) begin
         color_q       <= lk_result;
         color_valid_q <= lk_valid;
      end
   end

   assign color       = color_q;
   assign color_valid = color_valid_q;

endmodule

// File: tb/tb_cgb_palette_unit.sv
// Scoreboard bench for cgb_palette_unit at default parameters.
module tb_cgb_palette_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_en;
   logic [1:0]  reg_addr;
   logic        reg_wr;
   logic        reg_rd;
   logic [7:0]  reg_wdata;
   logic [7:0]  reg_rdata;
   logic        ppu_mode3;
   logic        lk_valid;
   logic [0:0]  lk_table;
   logic [2:0]  lk_palette;
   logic [1:0]  lk_color;
   logic        color_valid;
   logic [14:0] color;

   always #5 clk = ~clk;

   cgb_palette_unit dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_en      (cpu_en),
      .reg_addr    (reg_addr),
      .reg_wr      (reg_wr),
      .reg_rd      (reg_rd),
      .reg_wdata   (reg_wdata),
      .reg_rdata   (reg_rdata),
      .ppu_mode3   (ppu_mode3),
      .lk_valid    (lk_valid),
      .lk_table    (lk_table),
      .lk_palette  (lk_palette),
      .lk_color    (lk_color),
      .color_valid (color_valid),
      .color       (color)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model of both tables and their spec registers.
   logic [7:0] m_mem  [2][64];
   logic       m_ainc [2];
   logic [5:0] m_idx  [2];

   typedef struct {
      string       tag;
      logic [15:0] exp;
   } exp_t;
   exp_t sb[$];

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [15:0] exp);
      exp_t x;
      x.tag = tag;
      x.exp = exp;
      sb.push_back(x);
   endtask

   task automatic sb_pop(input logic [15:0] got);
      exp_t x;
      if (sb.size() == 0) begin
         check_val("sb_empty", 16'(sb.size()), 16'd1);
      end else begin
         x = sb.pop_front();
         check_val(x.tag, got, x.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int t = 0; t < 2; t++) begin
         for (int i = 0; i < 64; i++) m_mem[t][i] = 8'h00;
         m_ainc[t] = 1'b0;
         m_idx[t]  = 6'd0;
      end
   endtask

   task automatic wr_spec(input logic t, input logic [7:0] v);
      reg_addr  = {t, 1'b0};
      reg_wdata = v;
      reg_wr    = 1'b1;
      cpu_en    = 1'b1;
      tick();
      reg_wr    = 1'b0;
      m_ainc[t] = v[7];
      m_idx[t]  = v[5:0];
   endtask

   task automatic wr_data(input logic t, input logic [7:0] v);
      reg_addr  = {t, 1'b1};
      reg_wdata = v;
      reg_wr    = 1'b1;
      cpu_en    = 1'b1;
      tick();
      reg_wr = 1'b0;
      if (!ppu_mode3) m_mem[t][m_idx[t]] = v;
      if (m_ainc[t]) m_idx[t] = m_idx[t] + 6'd1;
   endtask

   task automatic rd_spec(input logic t, input string tag);
      reg_addr = {t, 1'b0};
      reg_rd   = 1'b1;
      sb_push(tag, {8'h00, m_ainc[t], 1'b1, m_idx[t]});
      @(negedge clk);
      sb_pop(16'(reg_rdata));
      reg_rd = 1'b0;
   endtask

   task automatic rd_data(input logic t, input string tag);
      reg_addr = {t, 1'b1};
      reg_rd   = 1'b1;
      sb_push(tag, {8'h00, (ppu_mode3 ? 8'hFF : m_mem[t][m_idx[t]])});
      @(negedge clk);
      sb_pop(16'(reg_rdata));
      reg_rd = 1'b0;
   endtask

   function automatic logic [15:0] lk_model(input logic v, input logic t, input logic [2:0] p,
                                            input logic [1:0] c);
      logic [5:0] a_lo;
      logic [5:0] a_hi;
      logic [7:0] hi;
      a_lo = {p, c, 1'b0};
      a_hi = {p, c, 1'b1};
      hi   = m_mem[t][a_hi];
      return {v, hi[6:0], m_mem[t][a_lo]};
   endfunction

   task automatic lookup(input logic t, input logic [2:0] p, input logic [1:0] c,
                         input string tag);
      lk_table   = t;
      lk_palette = p;
      lk_color   = c;
      lk_valid   = 1'b1;
      cpu_en     = 1'b1;
      sb_push(tag, lk_model(1'b1, t, p, c));
      tick();
      sb_pop({color_valid, color});
      lk_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0; cpu_en = 1'b0; reg_addr = '0; reg_wr = 1'b0; reg_rd = 1'b0;
      reg_wdata = '0; ppu_mode3 = 1'b0; lk_valid = 1'b0; lk_table = '0;
      lk_palette = '0; lk_color = '0;

      // Reset state
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      model_reset();
      rd_spec(1'b0, "rst_spec0");
      rd_spec(1'b1, "rst_spec1");
      rd_data(1'b0, "rst_data0");
      sb_push("rst_color", 16'h0000);
      @(negedge clk);
      sb_pop({color_valid, color});

      // Auto-increment burst on table 1 wraps the index
      wr_spec(1'b1, 8'h80);
      for (int i = 0; i < 64; i++) wr_data(1'b1, 8'(i));
      rd_spec(1'b1, "wrap_spec");
      rd_spec(1'b0, "t0_untouched");
      wr_spec(1'b1, 8'h3F);
      rd_data(1'b1, "byte63");
      rd_spec(1'b1, "spec_noainc");
      wr_spec(1'b1, 8'h21);
      rd_data(1'b1, "byte33");

      // Mode-3 lockout: store dropped, index still advances, read returns FF
      wr_spec(1'b0, 8'h86);
      ppu_mode3 = 1'b1;
      wr_data(1'b0, 8'hAA);
      rd_data(1'b0, "locked_rd");
      rd_spec(1'b0, "locked_idx");
      ppu_mode3 = 1'b0;
      wr_spec(1'b0, 8'h06);
      rd_data(1'b0, "locked_drop");

      // Lookup latency, valid tracking and hold while disabled
      wr_spec(1'b0, 8'h82);
      wr_data(1'b0, 8'h1F);
      wr_data(1'b0, 8'hFC);
      lookup(1'b0, 3'd0, 2'd1, "lk_001");
      cpu_en = 1'b0;
      sb_push("lk_hold", lk_model(1'b1, 1'b0, 3'd0, 2'd1));
      tick();
      sb_pop({color_valid, color});
      cpu_en = 1'b1;
      sb_push("lk_invalid", lk_model(1'b0, 1'b0, 3'd0, 2'd1));
      tick();
      sb_pop({color_valid, color});
      lookup(1'b1, 3'd2, 2'd1, "lk_t1");

      // Same-cycle write and lookup is read-before-write
      wr_spec(1'b0, 8'h3F);
      wr_data(1'b0, 8'h12);
      wr_spec(1'b0, 8'h3E);
      lk_table = 1'b0; lk_palette = 3'd7; lk_color = 2'd3; lk_valid = 1'b1;
      reg_addr = 2'b01; reg_wdata = 8'h55; reg_wr = 1'b1; cpu_en = 1'b1;
      sb_push("rbw_old", lk_model(1'b1, 1'b0, 3'd7, 2'd3));
      tick();
      sb_pop({color_valid, color});
      reg_wr = 1'b0; lk_valid = 1'b0;
      m_mem[0][62] = 8'h55;
      lookup(1'b0, 3'd7, 2'd3, "rbw_new");

      // Reset mid-burst with cpu_en low
      wr_spec(1'b1, 8'h80);
      wr_data(1'b1, 8'h11);
      reg_addr = 2'b11; reg_wdata = 8'h22; reg_wr = 1'b1; cpu_en = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0; reg_wr = 1'b0;
      model_reset();
      sb_push("rst2_color", 16'h0000);
      @(negedge clk);
      sb_pop({color_valid, color});
      rd_spec(1'b0, "rst2_spec0");
      rd_spec(1'b1, "rst2_spec1");
      rd_data(1'b1, "rst2_data1");
      wr_spec(1'b1, 8'h3F);
      rd_data(1'b1, "rst2_byte63");
      wr_spec(1'b0, 8'h02);
      rd_data(1'b0, "rst2_t0b2");

      check_val("sb_drained", 16'(sb.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
